// File: rtl/fib_request_scheduler.sv
// fib_request_scheduler
// Shares one double-rate Fibonacci iterator between N_REQ requesters.
// Requests are arbitrated round-robin, one is computed at a time, and the
// result is returned on a valid/ready response channel together with a
// flag telling whether the true F(n) needed more than W bits.
module fib_request_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 16,
  parameter int IDX_W = 8,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*IDX_W-1:0] req_index,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [W-1:0]           rsp_data,
  output logic                   rsp_overflow,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ID_W-1:0]  ptr_reg, ptr_next;
  logic [ID_W-1:0]  id_reg, id_next;
  logic [IDX_W-1:0] rem_reg, rem_next;
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     b_reg, b_next;
  logic             ovf_a_reg, ovf_a_next;
  logic             ovf_b_reg, ovf_b_next;

  logic             rsp_valid_reg, rsp_valid_next;
  logic [ID_W-1:0]  rsp_id_reg, rsp_id_next;
  logic [W-1:0]     rsp_data_reg, rsp_data_next;
  logic             rsp_ovf_reg, rsp_ovf_next;

  // Per-requester view of the packed index bus.
  logic [IDX_W-1:0] idx_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign idx_arr[gi] = req_index[gi*IDX_W +: IDX_W];
    end
  endgenerate

  // Round-robin search: first valid requester at or after the pointer, with wrap.
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;

  always_comb begin
    int              cand;
    logic [ID_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = ID_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Grant is only offered while idle; a pending reset suppresses it.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == IDLE) && !rst && grant_found &&
                             (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Iterator arithmetic. The second sum reuses the first, so
  // sum1 = a+b (next a) and sum2 = a+2b (next b) for the double step.
  // Overflow of each new term is sticky through its operands' flags.
  logic [W:0] sum1;
  logic [W:0] sum2;
  logic       ovf_sum1;
  logic       ovf_sum2;

  always_comb begin
    sum1     = {1'b0, a_reg} + {1'b0, b_reg};
    sum2     = {1'b0, sum1[W-1:0]} + {1'b0, b_reg};
    ovf_sum1 = sum1[W] | ovf_a_reg | ovf_b_reg;
    ovf_sum2 = sum2[W] | ovf_sum1 | ovf_b_reg;
  end

  // Next-state and datapath control for IDLE / COMPUTE / RESP.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    id_next        = id_reg;
    rem_next       = rem_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    ovf_a_next     = ovf_a_reg;
    ovf_b_next     = ovf_b_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_id_next    = rsp_id_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_ovf_next   = rsp_ovf_reg;

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          id_next    = grant_idx;
          rem_next   = idx_arr[grant_idx];
          a_next     = '0;
          b_next     = W'(1);
          ovf_a_next = 1'b0;
          ovf_b_next = 1'b0;
          ptr_next   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          state_next = COMPUTE;
        end
      end

      COMPUTE: begin
        if (rem_reg >= IDX_W'(2)) begin
          a_next     = sum1[W-1:0];
          b_next     = sum2[W-1:0];
          ovf_a_next = ovf_sum1;
          ovf_b_next = ovf_sum2;
          rem_next   = rem_reg - IDX_W'(2);
        end else if (rem_reg == IDX_W'(1)) begin
          a_next     = b_reg;
          b_next     = sum1[W-1:0];
          ovf_a_next = ovf_b_reg;
          ovf_b_next = ovf_sum1;
          rem_next   = '0;
        end else begin
          // a holds F(n); only its own flag decides the reported overflow.
          rsp_data_next  = a_reg;
          rsp_ovf_next   = ovf_a_reg;
          rsp_id_next    = id_reg;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight computation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      id_reg        <= '0;
      rem_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      ovf_a_reg     <= 1'b0;
      ovf_b_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
      rsp_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      id_reg        <= id_next;
      rem_reg       <= rem_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      ovf_a_reg     <= ovf_a_next;
      ovf_b_reg     <= ovf_b_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_ovf_reg   <= rsp_ovf_next;
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_id       = rsp_id_reg;
  assign rsp_data     = rsp_data_reg;
  assign rsp_overflow = rsp_ovf_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_fib_request_scheduler.sv
// Testbench for fib_request_scheduler: directed scenarios plus a randomized
// run, all checked against a plain-arithmetic Fibonacci / round-robin model.
module tb_fib_request_scheduler;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int IDX_W = 8;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*IDX_W-1:0] req_index = '0;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [ID_W-1:0]  rsp_id;
  logic [W-1:0]     rsp_data;
  logic             rsp_overflow;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;

  // Results of the most recent serve() call.
  logic [N-1:0]    s_ready;
  int              s_lat;
  bit              s_timeout;
  logic [W-1:0]    s_data;
  logic [ID_W-1:0] s_id;
  logic            s_ovf;
  bit              s_stable;
  bit              s_busy_gap;
  bit              s_rr_viol;
  bit              s_post_ok;

  fib_request_scheduler #(.N_REQ(N), .W(W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_overflow(rsp_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] fib_mod(input int n);
    logic [W-1:0] x, y, t;
    x = '0; y = 1;
    for (int i = 0; i < n; i++) begin t = x + y; x = y; y = t; end
    return x;
  endfunction

  // True F(n) >= 2^W, using values saturated at 2^W (Fibonacci is monotone).
  function automatic bit fib_ovf(input int n);
    longint x, y, t, lim;
    lim = longint'(1) << W;
    x = 0; y = 1;
    for (int i = 0; i < n; i++) begin
      t = x + y; if (t > lim) t = lim; x = y; y = t;
    end
    return x >= lim;
  endfunction

  function automatic int exp_lat(input int n);
    return (n + 1) / 2 + 1;
  endfunction

  function automatic int exp_grant(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idx(input int r, input int n);
    req_index[r*IDX_W +: IDX_W] = IDX_W'(n);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;
  endtask

  // Drives one accept/compute/response cycle for whatever requests are
  // currently asserted; holds rsp_ready low for 'hold' cycles in RESP.
  task automatic serve(input int hold);
    s_timeout = 0; s_stable = 1; s_busy_gap = 0; s_rr_viol = 0; s_post_ok = 1;
    s_lat = 0; s_data = '0; s_id = '0; s_ovf = 1'b0;
    #1 s_ready = req_ready;
    @(posedge clk); #1;
    req_valid = req_valid & ~s_ready;
    if (s_ready == '0) begin s_timeout = 1; return; end
    while (!rsp_valid) begin
      if (!busy) s_busy_gap = 1;
      if (req_ready != '0) s_rr_viol = 1;
      @(posedge clk); #1;
      s_lat++;
      if (s_lat > 400) begin s_timeout = 1; return; end
    end
    s_data = rsp_data; s_id = rsp_id; s_ovf = rsp_overflow;
    for (int h = 0; h <= hold; h++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== s_data || rsp_id !== s_id || rsp_overflow !== s_ovf)
        s_stable = 0;
      if (req_ready != '0) s_rr_viol = 1;
      if (!busy) s_busy_gap = 1;
      if (h == hold) rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) s_post_ok = 0;
    $display("txn grant=%b id=%0d lat=%0d data=%0d ovf=%0d hold=%0d", s_ready, s_id, s_lat, s_data, s_ovf, hold);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%0d exp=0", rsp_data); end
    checks++; if (rsp_id !== '0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_overflow !== 1'b0) begin failures++; $display("FAIL reset_rsp_overflow got=%b exp=0", rsp_overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
  endtask

  task automatic test_basic();
    set_idx(0, 10); req_valid = 4'b0001;
    serve(0);
    checks++; if (s_timeout || s_ready !== 4'b0001) begin failures++; $display("FAIL basic_grant got=%b exp=0001 timeout=%0d", s_ready, s_timeout); end
    checks++; if (s_lat != exp_lat(10)) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", s_lat, exp_lat(10)); end
    checks++; if (s_data !== fib_mod(10)) begin failures++; $display("FAIL basic_data got=%0d exp=%0d", s_data, fib_mod(10)); end
    checks++; if (s_id !== 2'd0 || s_ovf !== 1'b0) begin failures++; $display("FAIL basic_id_ovf got=%0d/%b exp=0/0", s_id, s_ovf); end
    model_ptr = 1;
  endtask

  task automatic test_small();
    for (int n = 0; n <= 2; n++) begin
      set_idx(1, n); req_valid = 4'b0010;
      serve(1);
      checks++; if (s_timeout || s_ready !== 4'b0010) begin failures++; $display("FAIL small_grant n=%0d got=%b exp=0010", n, s_ready); end
      checks++; if (s_data !== fib_mod(n) || s_id !== 2'd1) begin failures++; $display("FAIL small_data n=%0d got=%0d/%0d exp=%0d/1", n, s_data, s_id, fib_mod(n)); end
      checks++; if (s_lat != exp_lat(n)) begin failures++; $display("FAIL small_latency n=%0d got=%0d exp=%0d", n, s_lat, exp_lat(n)); end
      checks++; if (s_busy_gap || !s_post_ok) begin failures++; $display("FAIL small_busy n=%0d gap=%0d post_ok=%0d exp=0/1", n, s_busy_gap, s_post_ok); end
    end
    model_ptr = 2;
  endtask

  task automatic test_arbitration();
    int g;
    do_reset();
    set_idx(0, 5); set_idx(2, 6); set_idx(3, 7);
    req_valid = 4'b1101;
    for (int t = 0; t < 4; t++) begin
      if (t == 3) begin set_idx(0, 8); set_idx(3, 9); req_valid = 4'b1001; end
      g = exp_grant(req_valid, model_ptr);
      serve(0);
      checks++; if (s_timeout || s_ready !== (4'b0001 << g)) begin failures++; $display("FAIL arb_grant step=%0d got=%b exp_id=%0d", t, s_ready, g); end
      checks++; if (s_id !== ID_W'(g) || s_data !== fib_mod(5 + t)) begin failures++; $display("FAIL arb_rsp step=%0d got=%0d/%0d exp=%0d/%0d", t, s_id, s_data, g, fib_mod(5 + t)); end
      model_ptr = (g + 1) % N;
    end
    req_valid = '0;
  endtask

  task automatic test_overflow();
    int ns [3] = '{24, 25, 255};
    for (int k = 0; k < 3; k++) begin
      set_idx(2, ns[k]); req_valid = 4'b0100;
      serve(0);
      checks++; if (s_timeout || s_data !== fib_mod(ns[k])) begin failures++; $display("FAIL ovf_data n=%0d got=%0d exp=%0d", ns[k], s_data, fib_mod(ns[k])); end
      checks++; if (s_ovf !== fib_ovf(ns[k])) begin failures++; $display("FAIL ovf_flag n=%0d got=%b exp=%b", ns[k], s_ovf, fib_ovf(ns[k])); end
      checks++; if (s_lat != exp_lat(ns[k])) begin failures++; $display("FAIL ovf_latency n=%0d got=%0d exp=%0d", ns[k], s_lat, exp_lat(ns[k])); end
      model_ptr = 3;
    end
  endtask

  task automatic test_back_to_back();
    // Pointer is 3: request 1 first alone, then keep 3 pending through RESP.
    set_idx(1, 7); req_valid = 4'b0010;
    #1 checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_grant got=%b exp=0010", req_ready); end
    set_idx(3, 5);
    serve(5);  // req3 is raised below only after the accept
    checks++; if (s_timeout || !s_stable) begin failures++; $display("FAIL bp_stable timeout=%0d stable=%0d exp=0/1", s_timeout, s_stable); end
    checks++; if (s_data !== fib_mod(7)) begin failures++; $display("FAIL bp_data got=%0d exp=%0d", s_data, fib_mod(7)); end
    req_valid = 4'b1000;
    serve(0);
    checks++; if (s_timeout || s_ready !== 4'b1000) begin failures++; $display("FAIL bp_next_grant got=%b exp=1000", s_ready); end
    // Now with a competitor pending during RESP: it must wait for the handshake.
    set_idx(0, 9); set_idx(2, 4); req_valid = 4'b0101;
    serve(5);
    checks++; if (s_rr_viol || !s_stable || s_ready !== 4'b0001) begin failures++; $display("FAIL bp_hold rr_viol=%0d stable=%0d grant=%b exp=0/1/0001", s_rr_viol, s_stable, s_ready); end
    #1 checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_accept_next got=%b exp=0100", req_ready); end
    serve(0);
    checks++; if (s_timeout || s_data !== fib_mod(4) || s_id !== 2'd2) begin failures++; $display("FAIL bp_second got=%0d/%0d exp=%0d/2", s_data, s_id, fib_mod(4)); end
    model_ptr = 3;
  endtask

  task automatic test_reset_midcompute();
    bit seen;
    set_idx(1, 200); req_valid = 4'b0010;
    @(posedge clk); #1 req_valid = '0;
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_ptr = 0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_after_reset busy=%b rsp_valid=%b exp=0/0", busy, rsp_valid); end
    seen = 0;
    repeat (150) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
    checks++; if (seen) begin failures++; $display("FAIL mid_no_response got=1 exp=0"); end
    set_idx(0, 10); set_idx(3, 3); req_valid = 4'b1001;
    serve(0);
    checks++; if (s_timeout || s_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr_grant got=%b exp=0001", s_ready); end
    checks++; if (s_data !== 16'd55) begin failures++; $display("FAIL mid_fresh_data got=%0d exp=55", s_data); end
    serve(0);
    checks++; if (s_timeout || s_ready !== 4'b1000 || s_data !== fib_mod(3)) begin failures++; $display("FAIL mid_second got=%b/%0d exp=1000/%0d", s_ready, s_data, fib_mod(3)); end
    model_ptr = 0;
  endtask

  task automatic test_random();
    int pend_n [N];
    int g, r, n;
    req_valid = '0;
    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a < 2; a++) begin
        if (req_valid == '0 || $urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, N - 1);
          if (!req_valid[r]) begin
            n = $urandom_range(0, 255);
            set_idx(r, n); pend_n[r] = n; req_valid[r] = 1'b1;
          end
        end
      end
      g = exp_grant(req_valid, model_ptr);
      n = pend_n[g];
      serve($urandom_range(0, 3));
      checks++; if (s_timeout || s_ready !== (4'b0001 << g) || s_id !== ID_W'(g)) begin failures++; $display("FAIL rand_grant t=%0d got=%b/%0d exp_id=%0d", t, s_ready, s_id, g); end
      checks++; if (s_data !== fib_mod(n) || s_ovf !== fib_ovf(n)) begin failures++; $display("FAIL rand_result t=%0d n=%0d got=%0d/%b exp=%0d/%b", t, n, s_data, s_ovf, fib_mod(n), fib_ovf(n)); end
      checks++; if (s_lat != exp_lat(n) || !s_stable || s_rr_viol) begin failures++; $display("FAIL rand_timing t=%0d n=%0d lat=%0d exp=%0d stable=%0d rr_viol=%0d", t, n, s_lat, exp_lat(n), s_stable, s_rr_viol); end
      model_ptr = (g + 1) % N;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small();
    test_arbitration();
    test_overflow();
    test_back_to_back();
    test_reset_midcompute();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
